// File: rtl/cpu_sequencer.sv
// cpu_sequencer: microcode control unit for the 8-bit BasicCPU.
// Steps each instruction through T0..T4. The two fetch steps are the same for
// every opcode; the execute steps are decoded from the IR upper nibble.
// State advances on the falling clock edge, so the strobes are already stable
// when the datapath registers capture on the next rising edge.
module cpu_sequencer #(
  parameter int OPCODE_W = 4,
  parameter int T_MAX    = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_ir,
  input  logic       i_flag_c,
  input  logic       i_flag_z,
  output logic       o_pc_out_n,
  output logic       o_pc_inc,
  output logic       o_pc_load_n,
  output logic       o_mar_load_n,
  output logic       o_ram_out_n,
  output logic       o_ram_in_n,
  output logic       o_ir_load_n,
  output logic       o_ir_out_n,
  output logic       o_a_load_n,
  output logic       o_a_out_n,
  output logic       o_b_load_n,
  output logic       o_alu_out_n,
  output logic       o_alu_sub,
  output logic       o_flags_load_n,
  output logic       o_out_load_n,
  output logic       o_halted,
  output logic [2:0] o_step,
  output logic       o_instr_done
);

  localparam logic [2:0] T0     = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] T_LAST = 3'(T_MAX - 1);

  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  logic [2:0]          step;
  logic                halted;
  logic [OPCODE_W-1:0] opcode;
  logic                ir_operand_unused;

  // Active-high internal strobes; the _n ports are their inversions.
  logic pc_out, pc_inc, pc_load, mar_load, ram_out, ram_in, ir_load, ir_out;
  logic a_load, a_out, b_load, alu_out, alu_sub, flags_load, out_load, done;

  assign opcode            = i_ir[7 -: OPCODE_W];
  assign ir_operand_unused = ^i_ir[7-OPCODE_W:0];

  // Microcode decode: strobes from step, opcode and flags. Gating on reset
  // keeps every strobe released for the whole time reset is held, not just
  // after the state registers have cleared.
  always_comb begin
    pc_out = 1'b0; pc_inc = 1'b0; pc_load = 1'b0; mar_load = 1'b0;
    ram_out = 1'b0; ram_in = 1'b0; ir_load = 1'b0; ir_out = 1'b0;
    a_load = 1'b0; a_out = 1'b0; b_load = 1'b0; alu_out = 1'b0;
    alu_sub = 1'b0; flags_load = 1'b0; out_load = 1'b0; done = 1'b0;
    if (!i_reset && !halted) begin
      case (step)
        T0: begin
          pc_out = 1'b1; mar_load = 1'b1;
        end
        T1: begin
          ram_out = 1'b1; ir_load = 1'b1; pc_inc = 1'b1;
        end
        T2: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1; mar_load = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1; a_load = 1'b1; done = 1'b1;
            end
            OP_JMP: begin
              ir_out = 1'b1; pc_load = 1'b1; done = 1'b1;
            end
            OP_JC: begin
              ir_out = i_flag_c; pc_load = i_flag_c; done = 1'b1;
            end
            OP_JZ: begin
              ir_out = i_flag_z; pc_load = i_flag_z; done = 1'b1;
            end
            OP_OUT: begin
              a_out = 1'b1; out_load = 1'b1; done = 1'b1;
            end
            default: done = 1'b1;   // NOP, HLT and unused opcodes
          endcase
        end
        T3: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1; a_load = 1'b1; done = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1; b_load = 1'b1;
            end
            OP_STA: begin
              a_out = 1'b1; ram_in = 1'b1; done = 1'b1;
            end
            // Only reachable if the IR changed mid-instruction: end cleanly.
            default: done = 1'b1;
          endcase
        end
        T4: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1; a_load = 1'b1; flags_load = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
          done = 1'b1;
        end
        default: done = 1'b1;
      endcase
    end
  end

  // Step counter and halt latch, advanced on the falling edge.
  always_ff @(negedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      step   <= T0;
      halted <= 1'b0;
    end else if (halted) begin
      step <= T0;
    end else if (done || step >= T_LAST) begin
      step <= T0;
      if (opcode == OP_HLT && step == T2) halted <= 1'b1;
    end else begin
      step <= step + 3'd1;
    end
  end

  assign o_pc_out_n     = ~pc_out;
  assign o_pc_inc       = pc_inc;
  assign o_pc_load_n    = ~pc_load;
  assign o_mar_load_n   = ~mar_load;
  assign o_ram_out_n    = ~ram_out;
  assign o_ram_in_n     = ~ram_in;
  assign o_ir_load_n    = ~ir_load;
  assign o_ir_out_n     = ~ir_out;
  assign o_a_load_n     = ~a_load;
  assign o_a_out_n      = ~a_out;
  assign o_b_load_n     = ~b_load;
  assign o_alu_out_n    = ~alu_out;
  assign o_alu_sub      = alu_sub;
  assign o_flags_load_n = ~flags_load;
  assign o_out_load_n   = ~out_load;
  assign o_halted       = halted;
  assign o_step         = step;
  assign o_instr_done   = done;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for the BasicCPU control sequencer.
// Each instruction issued pushes its expected per-step strobe vectors; one
// vector is popped and compared on every rising edge (state moves on falling).
module tb_cpu_sequencer;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic [7:0] i_ir;
  logic       i_flag_c, i_flag_z;
  logic o_pc_out_n, o_pc_inc, o_pc_load_n, o_mar_load_n, o_ram_out_n;
  logic o_ram_in_n, o_ir_load_n, o_ir_out_n, o_a_load_n, o_a_out_n;
  logic o_b_load_n, o_alu_out_n, o_alu_sub, o_flags_load_n, o_out_load_n;
  logic o_halted, o_instr_done;
  logic [2:0] o_step;

  cpu_sequencer #(.OPCODE_W(4), .T_MAX(5)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_ir(i_ir),
    .i_flag_c(i_flag_c), .i_flag_z(i_flag_z),
    .o_pc_out_n(o_pc_out_n), .o_pc_inc(o_pc_inc), .o_pc_load_n(o_pc_load_n),
    .o_mar_load_n(o_mar_load_n), .o_ram_out_n(o_ram_out_n),
    .o_ram_in_n(o_ram_in_n), .o_ir_load_n(o_ir_load_n),
    .o_ir_out_n(o_ir_out_n), .o_a_load_n(o_a_load_n), .o_a_out_n(o_a_out_n),
    .o_b_load_n(o_b_load_n), .o_alu_out_n(o_alu_out_n),
    .o_alu_sub(o_alu_sub), .o_flags_load_n(o_flags_load_n),
    .o_out_load_n(o_out_load_n), .o_halted(o_halted), .o_step(o_step),
    .o_instr_done(o_instr_done)
  );

  always #5 i_clk = ~i_clk;

  // Active-high strobe bits of the observed vector; step sits in [19:17].
  localparam logic [16:0] PCO  = 17'h00001, PCI  = 17'h00002, PCL = 17'h00004;
  localparam logic [16:0] MARL = 17'h00008, RAMO = 17'h00010, RAMI = 17'h00020;
  localparam logic [16:0] IRL  = 17'h00040, IRO  = 17'h00080, AL  = 17'h00100;
  localparam logic [16:0] AO   = 17'h00200, BL   = 17'h00400, ALUO = 17'h00800;
  localparam logic [16:0] SUBB = 17'h01000, FL   = 17'h02000, OUTL = 17'h04000;
  localparam logic [16:0] DONE = 17'h08000, HALT = 17'h10000;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [19:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] observed();
    return {o_step, o_halted, o_instr_done, ~o_out_load_n, ~o_flags_load_n,
            o_alu_sub, ~o_alu_out_n, ~o_b_load_n, ~o_a_out_n, ~o_a_load_n,
            ~o_ir_out_n, ~o_ir_load_n, ~o_ram_in_n, ~o_ram_out_n,
            ~o_mar_load_n, ~o_pc_load_n, o_pc_inc, ~o_pc_out_n};
  endfunction

  function automatic logic [31:0] bus_drivers();
    return 32'(!o_pc_out_n) + 32'(!o_ram_out_n) + 32'(!o_ir_out_n)
         + 32'(!o_a_out_n) + 32'(!o_alu_out_n);
  endfunction

  task automatic push(input logic [2:0] s, input logic [16:0] bits);
    sb.push_back({s, bits});
  endtask

  // Expected behaviour of one instruction, written from the opcode table.
  task automatic issue(input logic [7:0] ir, input logic c, input logic z);
    i_ir = ir; i_flag_c = c; i_flag_z = z;
    push(3'd0, PCO | MARL);
    push(3'd1, RAMO | IRL | PCI);
    case (ir[7:4])
      4'h1: begin push(3'd2, IRO | MARL); push(3'd3, RAMO | AL | DONE); end
      4'h2: begin push(3'd2, IRO | MARL); push(3'd3, RAMO | BL);
                  push(3'd4, ALUO | AL | FL | DONE); end
      4'h3: begin push(3'd2, IRO | MARL); push(3'd3, RAMO | BL);
                  push(3'd4, ALUO | AL | FL | SUBB | DONE); end
      4'h4: begin push(3'd2, IRO | MARL); push(3'd3, AO | RAMI | DONE); end
      4'h5: push(3'd2, IRO | AL | DONE);
      4'h6: push(3'd2, IRO | PCL | DONE);
      4'h7: push(3'd2, (c ? (IRO | PCL) : 17'h0) | DONE);
      4'h8: push(3'd2, (z ? (IRO | PCL) : 17'h0) | DONE);
      4'hE: push(3'd2, AO | OUTL | DONE);
      4'hF: begin
        push(3'd2, DONE);
        for (int unsigned k = 0; k < 10; k++) push(3'd0, HALT);
      end
      default: push(3'd2, DONE);
    endcase
  endtask

  // Pop and compare one vector per rising edge until the queue drains,
  // then step just past the next falling edge ready for new stimulus.
  task automatic drain(input string tag);
    logic [19:0] e;
    while (sb.size() > 0) begin
      @(posedge i_clk);
      e = sb.pop_front();
      check(tag, 32'(observed()), 32'(e));
      check({tag, "_bus"}, 32'(bus_drivers() <= 1), 32'd1);
    end
    @(negedge i_clk); #1;
  endtask

  task automatic reset_pulse(input string tag);
    i_reset = 1'b1;
    #1 check(tag, 32'(observed()), 32'd0);
    @(negedge i_clk); #1;
    check({tag, "_hold"}, 32'(observed()), 32'd0);
    i_reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [19:0] e;
    i_reset = 1'b1; i_ir = 8'h00; i_flag_c = 1'b0; i_flag_z = 1'b0;
    #1 check("reset", 32'(observed()), 32'd0);
    @(negedge i_clk); #1;
    i_reset = 1'b0;

    issue(8'h23, 1'b0, 1'b1); drain("add");
    issue(8'h35, 1'b1, 1'b0); drain("sub");
    issue(8'h7A, 1'b1, 1'b0); drain("jc_taken");
    issue(8'h7A, 1'b0, 1'b1); drain("jc_not");
    issue(8'h84, 1'b0, 1'b1); drain("jz_taken");
    issue(8'h84, 1'b1, 1'b0); drain("jz_not");

    // Reset asserted while ADD sits in T3: strobes drop at once.
    issue(8'h23, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 4; k++) begin
      @(posedge i_clk);
      e = sb.pop_front();
      check("add_pre_rst", 32'(observed()), 32'(e));
    end
    sb.delete();
    #1 reset_pulse("rst_mid_t3");
    issue(8'h10, 1'b0, 1'b0); drain("lda_after_rst");

    // Every opcode once, random flags; 0x9-0xD follow the NOP table.
    for (int unsigned op = 0; op < 15; op++) begin
      issue({4'(op), 4'(op + 3)}, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      drain($sformatf("op%0h", op));
    end

    // HLT: halted, step parked at 0, no strobes for ten clocks.
    issue(8'hF0, 1'b1, 1'b1); drain("hlt");
    check("halted_persist", 32'({o_halted, o_step}), 32'h8);
    reset_pulse("rst_halted");
    issue(8'h5C, 1'b0, 1'b0); drain("ldi_after_halt");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Microcode control unit for the 8-bit BasicCPU.
- Steps each instruction through fetch and execute T-states.
- Drives the bus-enable and load strobes for the PC, MAR, RAM, IR, A, B, ALU, flags and output registers.
- Decodes the opcode from the IR upper nibble; conditional jumps use the registered carry/zero flags.

Parameters:
- OPCODE_W, 4, opcode width; opcode = i_ir[7:4].
- T_MAX, 5, number of step slots (T0..T4); step counter width 3.

Ports:
- i_clk  input  1  system clock; state advances on the falling edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_ir  input  8  instruction register contents.
- i_flag_c  input  1  registered carry flag.
- i_flag_z  input  1  registered zero flag.
- o_pc_out_n  output  1  PC drives bus (active low).
- o_pc_inc  output  1  PC increment (active high).
- o_pc_load_n  output  1  PC loads from bus.
- o_mar_load_n  output  1  MAR loads from bus.
- o_ram_out_n  output  1  RAM drives bus.
- o_ram_in_n  output  1  RAM writes from bus.
- o_ir_load_n  output  1  IR loads from bus.
- o_ir_out_n  output  1  IR low nibble drives bus (zero-extended).
- o_a_load_n  output  1  A loads from bus.
- o_a_out_n  output  1  A drives bus.
- o_b_load_n  output  1  B loads from bus.
- o_alu_out_n  output  1  ALU result drives bus (ALU read strobe).
- o_alu_sub  output  1  ALU subtract select.
- o_flags_load_n  output  1  flags register captures ALU flags.
- o_out_load_n  output  1  output register loads from bus.
- o_halted  output  1  CPU halted.
- o_step  output  3  current T-state, 0..4.
- o_instr_done  output  1  current step is the last step of the instruction.

Behaviour:
- Registered state:
  - step counter 0..4.
  - halted bit.
  - Both update on the negedge of i_clk, so strobes are stable before datapath posedges.
- Control outputs:
  - Combinational from step, opcode, flags and halted.
  - Deasserted means every _n output high and every active-high output low.
- Reset (async, any time, including mid-instruction):
  - step=0, halted=0, all strobes deasserted, o_instr_done=0.
  - Any partial instruction is abandoned.
- Fetch, common to all opcodes:
  - T0: pc_out_n=0, mar_load_n=0.
  - T1: ram_out_n=0, ir_load_n=0, pc_inc=1.
- Execute by opcode (unlisted steps have no strobes):
  - 0x0 NOP: T2 empty, last.
  - 0x1 LDA: T2 ir_out, mar_load; T3 ram_out, a_load, last.
  - 0x2 ADD: T2 ir_out, mar_load; T3 ram_out, b_load; T4 alu_out, a_load, flags_load, alu_sub=0, last.
  - 0x3 SUB: as ADD, with alu_sub=1 during T4 only.
  - 0x4 STA: T2 ir_out, mar_load; T3 a_out, ram_in, last.
  - 0x5 LDI: T2 ir_out, a_load, last.
  - 0x6 JMP: T2 ir_out, pc_load, last.
  - 0x7 JC: T2 ir_out and pc_load only if i_flag_c=1 (sampled combinationally in T2), else empty; last either way.
  - 0x8 JZ: same as JC, using i_flag_z.
  - 0xE OUT: T2 a_out, out_load, last.
  - 0xF HLT: T2 asserts o_instr_done; on that negedge halted←1.
  - 0x9–0xD: behave as NOP.
- Step advance:
  - If o_instr_done=1, step←0 at the next negedge.
  - Otherwise step←step+1.
  - Step never exceeds 4; T4 is always last.
- Halted:
  - Step held at 0 and all strobes deasserted, including fetch.
  - o_halted=1 until reset.
- Invariant: at most one *_out_n low in any step (no bus contention).
- i_ir is read only in T2..T4; its value during T0/T1 is don't-care.

Test Plan:
- Reset asserted mid-T3 of ADD → all strobes immediately deasserted, o_step=0; after release, the next negedge moves to step 1 and T0 fetch strobes are seen first.
- i_ir=0x23 (ADD) → strobes per step: T0 pc_out/mar_load, T1 ram_out/ir_load/pc_inc, T2 ir_out/mar_load, T3 ram_out/b_load, T4 alu_out/a_load/flags_load with alu_sub=0; o_instr_done only in T4; then step wraps to 0.
- i_ir=0x35 (SUB) → identical sequence with alu_sub=1 only in T4.
- i_ir=0x7A (JC):
  - i_flag_c=1 → T2 ir_out_n=0, pc_load_n=0.
  - i_flag_c=0 → T2 no strobes.
  - Both cases return to T0 after three steps.
- i_ir=0xF0 (HLT) → after T2, o_halted=1 and o_step stays 0 with no strobes for 10 clocks; reset clears o_halted.
- Sweep all 16 opcodes × all steps → at most one *_out_n low per step, and opcodes 0x9–0xD match NOP.
